ddr_arbiter: RTL
================

Name: ddr_arbiter

Overview:
- Shares one DDR controller instruction port (12-bit inst, inst_en, ready) among NumReq requesters, e.g. the sequencer oreg path and a DMA/refresh engine.
- Round-robin arbitration, one instruction per grant, with an optional lock for atomic multi-instruction sequences such as activate/write/precharge.
- Sits between the requesters and the DDR controller, in the controller's clock domain.

Parameters:
- NumReq, 3, number of requesters (2..4).
- InstSize, 12, width of one controller instruction.
- SettleCycles, 2, cycles after an issue during which ctl_ready is ignored (1..7).
- LockTimeout, 1024, watchdog limit in cycles (used only with DDRARB_TIMEOUT_EN).

Ports:
- clock  in  1  sole clock; all state is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NumReq  per-requester request level.
- req_lock  in  NumReq  requester wants to keep ownership after this instruction.
- req_inst  in  NumReq*InstSize  flattened instructions; requester i occupies bits [i*InstSize +: InstSize].
- req_ack  out  NumReq  one-cycle pulse: instruction of requester i issued.
- grant  out  NumReq  one-hot current/last owner; all zero when free.
- ctl_ready  in  1  controller ready.
- ctl_inst  out  InstSize  instruction to controller.
- ctl_inst_en  out  1  one-cycle instruction strobe.
- lock_err  out  1  sticky watchdog flag (tied 0 without the macro).

Behaviour:
- All outputs are registered.
- Reset (async, reset=0): ctl_inst=0, ctl_inst_en=0, req_ack=0, grant=0, lock_err=0, state=Idle, locked=0, last=NumReq-1 so requester 0 has first priority. Reset mid-issue aborts immediately; the controller sees ctl_inst_en fall asynchronously.
- States: Idle, Settle, Wait.
- Idle:
  - If ctl_ready=1 and an eligible req is present, pick winner w:
    - when locked, only the lock owner is eligible;
    - otherwise, w is the first asserted req scanning from last+1 with wrap-around.
  - Next cycle: ctl_inst=req_inst[w], ctl_inst_en=1, req_ack[w]=1, grant=onehot(w), last=w, locked=req_lock[w]. Go to Settle with cnt=SettleCycles-1.
  - If ctl_ready=0 or there is no eligible request, stay in Idle with no strobe.
- Settle: ctl_inst_en=0, req_ack=0, ctl_inst held. Decrement cnt; at cnt=0 go to Wait. ctl_ready is ignored in this state.
- Wait: stay until ctl_ready=1, then go to Idle. Arbitration is evaluated in Idle on the following cycle.
- Latency:
  - Request to strobe is 1 cycle.
  - Back-to-back issue spacing is at least SettleCycles+2 cycles when ready stays high.
- Requester rules:
  - Requester holds req and req_inst stable until it sees req_ack. The arbiter samples req_inst on the decision cycle only.
  - Dropping req before ack is legal; that request is simply not served.
  - After the ack the requester drops req or presents its next instruction.
- Lock release: in Idle, a locked owner with req_lock=0 and req=0 releases the lock. Normal round-robin resumes from last+1.
- A locked owner issuing with req_lock=0 releases the lock at that issue.
- grant stays on the last owner until a new winner is chosen or the lock is released. grant goes to 0 on release.
- Simultaneous requests: pure round-robin with no starvation. Each requester is served within NumReq grants when unlocked.
- ctl_ready toggling during Settle has no effect.

Optional Feature:
- Macro: DDRARB_TIMEOUT_EN.
- Defined:
  - A counter runs while locked=1 and the arbiter is in Idle with no request from the owner.
  - It resets on every issue by the owner.
  - On reaching LockTimeout the lock is force-released, grant goes to 0 and lock_err is set to 1.
  - lock_err is cleared only by reset.
- Undefined: no counter exists, lock_err is constant 0, and a lock is held indefinitely.

Test Plan:
- After reset release, req=3'b111, ctl_ready=1, SettleCycles=2 → acks in order 0,1,2,0; strobes 4 cycles apart; ctl_inst matches each source (e.g. 12'h0A1, 12'h0B2, 12'h0C3).
- req[1]=1 with ctl_ready=0 for 10 cycles → no strobe; ready rises at cycle 10 → ctl_inst_en at cycle 11 with ctl_inst=req_inst[1] and req_ack[1]=1.
- Requester 2 issues 3 instructions with req_lock=1 while req[0]=1 → all 3 go to requester 2 and grant=3'b100 throughout. req_lock[2] then drops → next grant goes to requester 0.
- Assert reset (low) during Settle → ctl_inst_en, req_ack and grant are 0 immediately. After release, requester 0 wins first.
- With DDRARB_TIMEOUT_EN and LockTimeout=16, requester 1 locks then idles → at cycle 16 the lock is released, lock_err=1, and requester 0 is served next. Without the macro the lock holds for 100+ cycles and lock_err=0.
- ctl_ready pulsed low only inside Settle → the arbiter does not hang; the next issue occurs at exactly SettleCycles+2 spacing.

Source files
------------

// File: rtl/ddr_arbiter.sv
// rtl/ddr_arbiter.sv - round-robin arbiter sharing one DDR controller instruction port, with lock
// Optional lock watchdog enabled by DDRARB_TIMEOUT_EN.
module ddr_arbiter #(
    parameter int NumReq       = 3,
    parameter int InstSize     = 12,
    parameter int SettleCycles = 2,
    parameter int LockTimeout  = 1024
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NumReq-1:0]          req,
    input  logic [NumReq-1:0]          req_lock,
    input  logic [NumReq*InstSize-1:0] req_inst,
    output logic [NumReq-1:0]          req_ack,
    output logic [NumReq-1:0]          grant,
    input  logic                       ctl_ready,
    output logic [InstSize-1:0]        ctl_inst,
    output logic                       ctl_inst_en,
    output logic                       lock_err
);
    localparam int IdxW = $clog2(NumReq);
    localparam int CntW = 3;

    if (NumReq < 2 || NumReq > 4 || SettleCycles < 1 || SettleCycles > 7 || LockTimeout < 2) begin : g_bad_cfg
        $error("ddr_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        Idle,
        Settle,
        Wait
    } state_t;

    state_t              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [IdxW-1:0]     last_q, last_d;
    logic                locked_q, locked_d;
    logic [NumReq-1:0]   grant_d, ack_d;
    logic [InstSize-1:0] inst_d;
    logic                en_d;
    logic [IdxW-1:0]     rr_win;
    logic                rr_hit;
    logic [IdxW-1:0]     win;
    logic                issue;

`ifdef DDRARB_TIMEOUT_EN
    localparam int ToW = $clog2(LockTimeout + 1);
    logic [ToW-1:0] to_q, to_d;
    logic           err_d;
`endif

    // Descending scan so the requester closest after last wins.
    always_comb begin
        int idx;
        idx    = 0;
        rr_win = last_q;
        rr_hit = 1'b0;
        for (int k = NumReq; k >= 1; k--) begin
            idx = (int'(last_q) + k) % NumReq;
            if (req[idx]) begin
                rr_win = IdxW'(idx);
                rr_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_d   = last_q;
        locked_d = locked_q;
        grant_d  = grant;
        ack_d    = '0;
        en_d     = 1'b0;
        inst_d   = ctl_inst;
        issue    = 1'b0;
        win      = last_q;
        case (state_q)
            Idle: begin
                if (locked_q) begin
                    if (!req[last_q] && !req_lock[last_q]) begin
                        locked_d = 1'b0;
                        grant_d  = '0;
                    end else if (ctl_ready && req[last_q]) begin
                        issue = 1'b1;
                        win   = last_q;
                    end
                end else if (ctl_ready && rr_hit) begin
                    issue = 1'b1;
                    win   = rr_win;
                end
                if (issue) begin
                    state_d  = Settle;
                    cnt_d    = CntW'(SettleCycles - 1);
                    last_d   = win;
                    locked_d = req_lock[win];
                    grant_d  = NumReq'(1) << win;
                    ack_d    = NumReq'(1) << win;
                    en_d     = 1'b1;
                    inst_d   = req_inst[win*InstSize +: InstSize];
                end
            end
            Settle: begin
                if (cnt_q == '0) state_d = Wait;
                else             cnt_d   = cnt_q - 1'b1;
            end
            Wait: begin
                if (ctl_ready) state_d = Idle;
            end
            default: state_d = Idle;
        endcase
`ifdef DDRARB_TIMEOUT_EN
        to_d  = to_q;
        err_d = lock_err;
        if (!locked_q || issue) begin
            to_d = '0;
        end else if (state_q == Idle && !req[last_q] && req_lock[last_q]) begin
            if (to_q == ToW'(LockTimeout - 1)) begin
                to_d     = '0;
                locked_d = 1'b0;
                grant_d  = '0;
                err_d    = 1'b1;
            end else begin
                to_d = to_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= Idle;
            cnt_q       <= '0;
            last_q      <= IdxW'(NumReq - 1);
            locked_q    <= 1'b0;
            grant       <= '0;
            req_ack     <= '0;
            ctl_inst_en <= 1'b0;
            ctl_inst    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            locked_q    <= locked_d;
            grant       <= grant_d;
            req_ack     <= ack_d;
            ctl_inst_en <= en_d;
            ctl_inst    <= inst_d;
        end
    end

`ifdef DDRARB_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_q     <= '0;
            lock_err <= 1'b0;
        end else begin
            to_q     <= to_d;
            lock_err <= err_d;
        end
    end
`else
    assign lock_err = 1'b0;
`endif

endmodule
